// File: rtl/uart_rx_if.sv
// Host-side bus of the UART receiver: serial input, FIFO pop, error clear
// and the FIFO/status outputs.
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          iRX_DATA;
  logic                          iRD_EN;
  logic                          iERR_CLR;
  logic [7:0]                    oRX_BYTE;
  logic                          oRX_EMPTY;
  logic                          oRX_FULL;
  logic [$clog2(FIFO_DEPTH):0]   oRX_COUNT;
  logic                          oFRAME_ERR;
  logic                          oOVERRUN;
  logic                          oBUSY;

  modport master (
    output iRX_DATA, iRD_EN, iERR_CLR,
    input  oRX_BYTE, oRX_EMPTY, oRX_FULL, oRX_COUNT, oFRAME_ERR, oOVERRUN, oBUSY
  );

  modport slave (
    input  iRX_DATA, iRD_EN, iERR_CLR,
    output oRX_BYTE, oRX_EMPTY, oRX_FULL, oRX_COUNT, oFRAME_ERR, oOVERRUN, oBUSY
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, show-ahead FIFO,
// sticky framing/overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          rx_meta, rxs;
  logic          push, frame_set, ovr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic [7:0]    last_q;
  logic          pop, full, frame_err, overrun;

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = bus.iRD_EN && (count != '0);

  // Two-flop synchronizer; idle level is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.iRX_DATA;
      rxs     <= rx_meta;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
    end
  end

  // Next-state logic; the STOP sample produces push / frame / overrun events
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CW'(1);
    idx_nx    = idx;
    shift_nx  = shift;
    push      = 1'b0;
    frame_set = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rxs) state_nx = START;
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          // a start bit gone high again by mid-bit is treated as a glitch
          state_nx = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_nx   = '0;
          shift_nx = {rxs, shift[7:1]};
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_nx = '0;
          if (rxs) begin
            // a same-cycle pop frees a slot in a full FIFO
            if (!full || bus.iRD_EN) push = 1'b1;
            else                     ovr_set = 1'b1;
            state_nx = IDLE;
          end else begin
            frame_set = 1'b1;
            state_nx  = BRK;
          end
        end
      end
      BRK: begin
        cnt_nx = '0;
        // hold here so a line stuck low is not read as repeated start bits
        if (rxs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Show-ahead FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        mem[wp] <= shift;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // remembers the head so the output holds once the FIFO drains
      if (count != '0) last_q <= mem[rp];
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)         frame_err <= 1'b1;
      else if (bus.iERR_CLR) frame_err <= 1'b0;
      if (ovr_set)           overrun   <= 1'b1;
      else if (bus.iERR_CLR) overrun   <= 1'b0;
    end
  end

  assign bus.oRX_BYTE   = (count != '0) ? mem[rp] : last_q;
  assign bus.oRX_EMPTY  = (count == '0);
  assign bus.oRX_FULL   = full;
  assign bus.oRX_COUNT  = count;
  assign bus.oFRAME_ERR = frame_err;
  assign bus.oOVERRUN   = overrun;
  assign bus.oBUSY      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed serial frames, expected bytes queued at send
// time and compared by a monitor whenever the host pops the FIFO.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q [$];

  uart_rx_if #(.FIFO_DEPTH(FD)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one frame. stop_bit selects the stop level; timing checks the
  // exact cycle the byte appears; rd_at_push pops on the push cycle;
  // abort_at (>0) stops driving after that many bit-cycles.
  task automatic send(input logic [7:0] b, input logic stop_bit,
                      input bit timing, input bit rd_at_push, input int abort_at);
    for (int k = 0; k < 10 * CPB; k++) begin
      if (abort_at > 0 && k == abort_at) return;
      if (k / CPB == 0)      bus.iRX_DATA = 1'b0;
      else if (k / CPB == 9) bus.iRX_DATA = stop_bit;
      else                   bus.iRX_DATA = b[k / CPB - 1];
      tick();
      // stop sample lands on edge 155 after the start edge
      if (timing && k == 153) chk("empty_before_stop", 32'(bus.oRX_EMPTY), 32'd1);
      if (timing && k == 154) chk("empty_after_stop",  32'(bus.oRX_EMPTY), 32'd0);
      if (rd_at_push && k == 153) bus.iRD_EN = 1'b1;
      if (rd_at_push && k == 154) bus.iRD_EN = 1'b0;
    end
    bus.iRX_DATA = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.iRX_DATA = 1'b1;
    repeat (n) tick();
  endtask

  task automatic rd();
    bus.iRD_EN = 1'b1;
    tick();
    bus.iRD_EN = 1'b0;
    tick();
  endtask

  task automatic clr();
    bus.iERR_CLR = 1'b1;
    tick();
    bus.iERR_CLR = 1'b0;
    tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(bus.oRX_EMPTY),  32'd1);
    chk({tag, "_full"},  32'(bus.oRX_FULL),   32'd0);
    chk({tag, "_count"}, 32'(bus.oRX_COUNT),  32'd0);
    chk({tag, "_byte"},  32'(bus.oRX_BYTE),   32'd0);
    chk({tag, "_ferr"},  32'(bus.oFRAME_ERR), 32'd0);
    chk({tag, "_ovr"},   32'(bus.oOVERRUN),   32'd0);
    chk({tag, "_busy"},  32'(bus.oBUSY),      32'd0);
  endtask

  // Scoreboard monitor: every effective pop must match the oldest queued byte
  always @(negedge clk) begin
    if (reset && bus.iRD_EN && !bus.oRX_EMPTY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no data", bus.oRX_BYTE);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.oRX_BYTE !== e) begin
          errors++;
          $display("FAIL pop_byte: got %0h expected %0h", bus.oRX_BYTE, e);
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.iRX_DATA = 1'b1;
    bus.iRD_EN   = 1'b0;
    bus.iERR_CLR = 1'b0;
    repeat (3) tick();
    chk_reset_state("por");
    reset = 1'b1;
    idle(5);

    // basic byte with exact arrival timing
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b1, 1'b0, 0);
    idle(4);
    chk("a5_count", 32'(bus.oRX_COUNT), 32'd1);
    chk("a5_ferr",  32'(bus.oFRAME_ERR), 32'd0);
    chk("a5_ovr",   32'(bus.oOVERRUN),   32'd0);
    rd();
    chk("a5_empty", 32'(bus.oRX_EMPTY), 32'd1);

    // 5-cycle low glitch
    bus.iRX_DATA = 1'b0;
    repeat (5) tick();
    bus.iRX_DATA = 1'b1;
    chk("glitch_busy", 32'(bus.oBUSY), 32'd1);
    repeat (8) tick();
    chk("glitch_idle",  32'(bus.oBUSY),      32'd0);
    chk("glitch_count", 32'(bus.oRX_COUNT),  32'd0);
    chk("glitch_ferr",  32'(bus.oFRAME_ERR), 32'd0);

    // framing error followed by a held-low line
    send(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    bus.iRX_DATA = 1'b0;
    chk("ferr_set",   32'(bus.oFRAME_ERR), 32'd1);
    chk("ferr_empty", 32'(bus.oRX_EMPTY),  32'd1);
    repeat (40) tick();
    idle(20);
    chk("break_count", 32'(bus.oRX_COUNT), 32'd0);
    chk("break_busy",  32'(bus.oBUSY),     32'd0);
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, 1'b0, 1'b0, 0);
    idle(4);
    chk("x12_count", 32'(bus.oRX_COUNT), 32'd1);
    rd();
    clr();
    chk("ferr_clr", 32'(bus.oFRAME_ERR), 32'd0);

    // overrun: five bytes, no reads
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send(8'(b), 1'b1, 1'b0, 1'b0, 0);
      idle(2);
    end
    chk("ovr_full",  32'(bus.oRX_FULL),  32'd1);
    chk("ovr_count", 32'(bus.oRX_COUNT), 32'd4);
    chk("ovr_flag",  32'(bus.oOVERRUN),  32'd1);
    repeat (4) rd();
    chk("ovr_drained", 32'(bus.oRX_EMPTY), 32'd1);
    clr();
    chk("ovr_clr", 32'(bus.oOVERRUN), 32'd0);

    // full FIFO with a pop on the push cycle
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(8'h11 + 8'(b));
      send(8'h11 + 8'(b), 1'b1, 1'b0, 1'b0, 0);
      idle(2);
    end
    chk("fp_full_before", 32'(bus.oRX_FULL), 32'd1);
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, 1'b0, 1'b1, 0);
    idle(2);
    chk("fp_ovr",   32'(bus.oOVERRUN),  32'd0);
    chk("fp_count", 32'(bus.oRX_COUNT), 32'd4);
    chk("fp_head",  32'(bus.oRX_BYTE),  32'h12);
    repeat (4) rd();
    chk("fp_empty", 32'(bus.oRX_EMPTY), 32'd1);

    // reset in the middle of data bit 4
    send(8'hFF, 1'b1, 1'b0, 1'b0, 5 * CPB + 6);
    reset        = 1'b0;
    bus.iRX_DATA = 1'b1;
    #2;
    chk_reset_state("midrst");
    tick();
    reset = 1'b1;
    idle(30);
    chk("midrst_count", 32'(bus.oRX_COUNT), 32'd0);
    chk("midrst_busy",  32'(bus.oBUSY),     32'd0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 1'b0, 1'b0, 0);
    idle(4);
    chk("x81_count", 32'(bus.oRX_COUNT), 32'd1);
    rd();
    chk("x81_empty", 32'(bus.oRX_EMPTY), 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart of the UART transmit serializer.
- Consumes an asynchronous 8N1 serial line, samples it at the centre of each bit using a system-clock bit-period counter, and checks the stop bit.
- Accepted bytes are pushed into a small show-ahead FIFO read by the host/bus side.
- Framing and overrun errors are reported as sticky flags.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range 8..65535
FIFO_DEPTH, 4, receive FIFO entries; must be a power of two, at least 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
iRX_DATA  input  1  serial line, idle high, asynchronous to clk
iRD_EN  input  1  pop request for the FIFO head
iERR_CLR  input  1  one-cycle pulse that clears both sticky error flags
oRX_BYTE  output  8  FIFO head byte; valid only while oRX_EMPTY=0
oRX_EMPTY  output  1  FIFO empty
oRX_FULL  output  1  FIFO full
oRX_COUNT  output  clog2(FIFO_DEPTH)+1  current number of FIFO entries
oFRAME_ERR  output  1  sticky: a stop bit was sampled low
oOVERRUN  output  1  sticky: a good byte was dropped because the FIFO was full
oBUSY  output  1  receiver is in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-low):
  - State=IDLE; bit counter, bit index, shift register, FIFO pointers and count all 0.
  - Synchronizer flops = 1.
  - Outputs: oRX_EMPTY=1, oRX_FULL=0, oRX_COUNT=0, oRX_BYTE=0, both error flags=0, oBUSY=0.
  - Reset mid-frame abandons the frame; no partial byte is ever pushed.
- Input: iRX_DATA passes through a 2-flop synchronizer (rxs). All decisions below use rxs. Two cycles of input latency.
- HALF = CLKS_PER_BIT/2, integer division. Bit counter width = clog2(CLKS_PER_BIT).
- States and transitions:
  - IDLE: rxs=0 -> START, counter=0.
  - START: counter counts up; at counter==HALF-1:
    - rxs=0 -> DATA, counter=0, index=0.
    - rxs=1 -> IDLE. This is glitch rejection; no flag is set.
  - DATA: at counter==CLKS_PER_BIT-1:
    - Shift rxs in LSB-first (bit i lands in shift[i]); counter=0.
    - After index 7 -> STOP; otherwise index+1.
  - STOP: at counter==CLKS_PER_BIT-1, sample rxs:
    - rxs=1: push the shifted byte if the FIFO is not full; otherwise set oOVERRUN and drop the byte. Then -> IDLE.
    - rxs=0: set oFRAME_ERR, discard the byte, -> BREAK.
  - BREAK: wait for rxs=1, then -> IDLE. This prevents a held-low line from being read as repeated start bits.
- Sample points fall mid-bit. A pushed byte appears at oRX_BYTE / oRX_EMPTY=0 on the cycle after the stop-bit sample.
- FIFO (show-ahead):
  - oRX_BYTE always reflects the head entry; it holds its last value when empty.
  - iRD_EN while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. oRX_COUNT counts 0..FIFO_DEPTH.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push and pop in the same cycle while full: the pop frees a slot, the push succeeds, oOVERRUN is not set.
  - Push and pop in the same cycle while empty: the pop is ignored, count becomes 1.
- Error flags:
  - Each set condition is sticky until an iERR_CLR pulse.
  - Set and iERR_CLR in the same cycle: set wins.
  - Flags have no effect on reception or the FIFO.

Test Plan:
- CLKS_PER_BIT=16: send 0xA5 (line low 16 cycles, then bits 1,0,1,0,0,1,0,1 LSB-first, then stop high) -> oRX_EMPTY falls exactly 1 cycle after the stop sample; oRX_BYTE=0xA5; oRX_COUNT=1; no error flags.
- Low glitch of 5 cycles on an idle line -> returns to IDLE at START+HALF; FIFO unchanged; oBUSY pulses then clears; no flags.
- Frame 0x3C with stop bit held low, line then low for 40 cycles, then high -> oFRAME_ERR=1; FIFO empty; no second byte received; next frame 0x12 received correctly; iERR_CLR -> oFRAME_ERR=0.
- FIFO_DEPTH=4: send 0x01..0x05 with no reads -> oRX_FULL=1; oRX_COUNT=4; oOVERRUN=1; reads return 0x01,0x02,0x03,0x04 in order, then oRX_EMPTY=1.
- FIFO full with iRD_EN asserted on the push cycle of a 5th byte 0x55 -> oOVERRUN stays 0; count stays 4; head advances; 0x55 is read last.
- Assert reset during DATA bit 4 of 0xFF, then release -> all outputs at reset values; no byte is pushed; the next complete frame 0x81 is received correctly.
